// File: rtl/unidade_busca_pkg.sv
// unidade_busca_pkg
// Shared definitions for the instruction fetch unit:
//   estado_e     - FSM state encoding (mirrored as localparam constants)
//   HALT_OPCODE  - opcode that stops fetching once it is accepted downstream
//   PC_W         - program counter / memory address width
//   INSTR_W      - instruction byte width
// Optional feature macro used by the unit: UNIDADE_BUSCA_STEP_EN.
package unidade_busca_pkg;

   localparam int PC_W    = 4;
   localparam int INSTR_W = 8;

   localparam logic [3:0] HALT_OPCODE = 4'hF;

   typedef enum logic [2:0] {
      E_IDLE  = 3'd0,
      E_FETCH = 3'd1,
      E_WAIT  = 3'd2,
      E_ISSUE = 3'd3,
      E_HALT  = 3'd4
   } estado_e;

   // Plain constants with the same encoding, for legacy code that compares
   // against raw vectors.
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_ISSUE = 3'd3;
   localparam logic [2:0] S_HALT  = 3'd4;

endpackage

// File: rtl/unidade_busca_if.sv
// unidade_busca_if
// Memory bus plus downstream instruction handshake of the fetch unit.
//   mem_addr/mem_rd/mem_data  - program memory read (data one cycle after mem_rd)
//   instr_out/opcode/operando - held instruction byte and its two nibbles
//   instr_valid/instr_ready   - downstream handshake
//   jump_en/jump_addr         - redirect, looked at only on the handshake edge
//   estado                    - current FSM state (debug visibility)
// Handshake: an instruction transfers on a rising clock edge where
// instr_valid and instr_ready are both 1; while instr_valid is 1 and no
// transfer has happened, instr_out does not change. instr_ready while
// instr_valid is 0 means nothing.
interface unidade_busca_if;
   import unidade_busca_pkg::*;

   logic [PC_W-1:0]    mem_addr;
   logic               mem_rd;
   logic [INSTR_W-1:0] mem_data;
   logic [INSTR_W-1:0] instr_out;
   logic [3:0]         opcode;
   logic [3:0]         operando;
   logic               instr_valid;
   logic               instr_ready;
   logic               jump_en;
   logic [PC_W-1:0]    jump_addr;
   logic [2:0]         estado;

   // Fetch unit side.
   modport master (
      output mem_addr, mem_rd, instr_out, opcode, operando, instr_valid, estado,
      input  mem_data, instr_ready, jump_en, jump_addr
   );

   // Memory / downstream stage side.
   modport slave (
      input  mem_addr, mem_rd, instr_out, opcode, operando, instr_valid, estado,
      output mem_data, instr_ready, jump_en, jump_addr
   );

endinterface

// File: rtl/unidade_busca_contador_pc.sv
// contador_pc
// Program counter register.
//   clock, reset - rising-edge clock, synchronous active-high reset (pc=0)
//   load         - load load_val (wins over inc)
//   inc          - pc+1, wrapping from 4'hF to 4'h0
//   load_val     - jump target
//   pc           - current value
module contador_pc
   import unidade_busca_pkg::*;
(
   input  logic            clock,
   input  logic            reset,
   input  logic            load,
   input  logic            inc,
   input  logic [PC_W-1:0] load_val,
   output logic [PC_W-1:0] pc
);

   always_ff @(posedge clock) begin
      if (reset) begin
         pc <= '0;
      end else if (load) begin
         pc <= load_val;
      end else if (inc) begin
         // Natural modulo-16 wrap, no carry out.
         pc <= pc + 1'b1;
      end
   end

endmodule

// File: rtl/unidade_busca.sv
// unidade_busca
// Instruction fetch unit: reads one byte per instruction from program memory
// at pc, holds it, offers it downstream and advances or redirects pc when it
// is accepted. A HALT_OPCODE instruction stops the unit until reset.
//   clock, reset - rising-edge clock, synchronous active-high reset
//   start        - level, leaves IDLE
//   bus          - unidade_busca_if.master (memory bus + instruction handshake)
//   pc           - program counter (also drives bus.mem_addr)
//   halted       - halt instruction has been accepted
//   step         - single-step advance, only with UNIDADE_BUSCA_STEP_EN
// Optional feature macro: UNIDADE_BUSCA_STEP_EN.
module unidade_busca
   import unidade_busca_pkg::*;
(
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   unidade_busca_if.master bus,
   output logic [PC_W-1:0] pc,
   output logic            halted
`ifdef UNIDADE_BUSCA_STEP_EN
   ,
   input  logic            step
`endif
);

   logic [2:0]         estado_q;
   logic [INSTR_W-1:0] instr_q;
   logic               aguarda_step;
   logic               handshake;
   logic               is_halt;
   logic               pc_load;
   logic               pc_inc;

   assign is_halt   = (instr_q[7:4] == HALT_OPCODE);
   assign handshake = bus.instr_valid && bus.instr_ready;
   // jump_en/jump_addr only matter here, on the accepting edge.
   assign pc_load   = handshake && !is_halt && bus.jump_en;
   assign pc_inc    = handshake && !is_halt && !bus.jump_en;

   contador_pc u_contador_pc (
      .clock    (clock),
      .reset    (reset),
      .load     (pc_load),
      .inc      (pc_inc),
      .load_val (bus.jump_addr),
      .pc       (pc)
   );

`ifdef UNIDADE_BUSCA_STEP_EN
   // Set after a non-halt handshake: the unit parks in ISSUE with nothing
   // offered until step releases it into the next fetch.
   always_ff @(posedge clock) begin
      if (reset) begin
         aguarda_step <= 1'b0;
      end else if (estado_q == S_ISSUE) begin
         if (aguarda_step) begin
            if (step) aguarda_step <= 1'b0;
         end else if (handshake && !is_halt) begin
            aguarda_step <= 1'b1;
         end
      end
   end
`else
   assign aguarda_step = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q <= S_IDLE;
         instr_q  <= '0;
      end else begin
         case (estado_q)
            S_IDLE:  if (start) estado_q <= S_FETCH;
            S_FETCH: estado_q <= S_WAIT;
            S_WAIT: begin
               instr_q  <= bus.mem_data;
               estado_q <= S_ISSUE;
            end
            S_ISSUE: begin
`ifdef UNIDADE_BUSCA_STEP_EN
               if (aguarda_step) begin
                  if (step) estado_q <= S_FETCH;
               end else if (handshake) begin
                  // Non-halt case stays in ISSUE with aguarda_step set.
                  if (is_halt) estado_q <= S_HALT;
               end
`else
               if (handshake) estado_q <= is_halt ? S_HALT : S_FETCH;
`endif
            end
            S_HALT:  estado_q <= S_HALT;
            default: estado_q <= S_IDLE;
         endcase
      end
   end

   assign bus.mem_addr    = pc;
   assign bus.mem_rd      = (estado_q == S_FETCH);
   assign bus.instr_out   = instr_q;
   assign bus.opcode      = instr_q[7:4];
   assign bus.operando    = instr_q[3:0];
   assign bus.instr_valid = (estado_q == S_ISSUE) && !aguarda_step;
   assign bus.estado      = estado_q;
   assign halted          = (estado_q == S_HALT);

endmodule

// File: tb/tb_unidade_busca.sv
// tb_unidade_busca
// Directed bench for unidade_busca: a 16-byte program memory model answers
// mem_rd one cycle later; a linear sequence of steps drives the unit and
// checks every observation against hand-computed values.
// Optional feature macro: UNIDADE_BUSCA_STEP_EN (adds the step scenario).
module tb_unidade_busca;
   import unidade_busca_pkg::*;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [3:0] pc;
   logic       halted;
`ifdef UNIDADE_BUSCA_STEP_EN
   logic       step = 1'b1;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0] mem [16];
   logic [7:0] held;
   int         n_rd;

   unidade_busca_if bus ();

   unidade_busca dut (
      .clock  (clock),
      .reset  (reset),
      .start  (start),
      .bus    (bus.master),
      .pc     (pc),
      .halted (halted)
`ifdef UNIDADE_BUSCA_STEP_EN
      ,
      .step   (step)
`endif
   );

   // ---------------- clock ----------------
   always #5 clock = ~clock;

   // ---------------- memory model ----------------
   always @(posedge clock) begin
      if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Edge that completes a non-halt handshake; in step builds (step held 1)
   // the unit spends one extra cycle parked in ISSUE before FETCH.
   task automatic hs_tick();
      tick();
`ifdef UNIDADE_BUSCA_STEP_EN
      tick();
`endif
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_estado"}, 32'(bus.estado), 32'(S_IDLE));
      chk({tag, "_pc"}, 32'(pc), 32'h0);
      chk({tag, "_instr"}, 32'(bus.instr_out), 32'h0);
      chk({tag, "_rd"}, 32'(bus.mem_rd), 32'h0);
      chk({tag, "_valid"}, 32'(bus.instr_valid), 32'h0);
      chk({tag, "_halted"}, 32'(halted), 32'h0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
      mem[0]  = 8'h23;
      mem[1]  = 8'h45;
      mem[2]  = 8'h67;
      mem[10] = 8'h17;
      mem[15] = 8'h31;
      bus.instr_ready = 1'b0;
      bus.jump_en     = 1'b0;
      bus.jump_addr   = 4'h0;

      // Reset state
      tick();
      tick();
      reset = 1'b0;
      chk_idle("reset");
      tick();
      chk("idle_hold", 32'(bus.estado), 32'(S_IDLE));

      // Latency: start in cycle 0
      start = 1'b1;
      bus.instr_ready = 1'b1;
      tick();                                         // cycle 1
      start = 1'b0;
      chk("c1_rd", 32'(bus.mem_rd), 32'h1);
      chk("c1_addr", 32'(bus.mem_addr), 32'h0);
      chk("c1_valid", 32'(bus.instr_valid), 32'h0);
      tick();                                         // cycle 2
      chk("c2_rd", 32'(bus.mem_rd), 32'h0);
      chk("c2_valid", 32'(bus.instr_valid), 32'h0);
      tick();                                         // cycle 3
      chk("c3_valid", 32'(bus.instr_valid), 32'h1);
      chk("c3_instr", 32'(bus.instr_out), 32'h23);
      chk("c3_opcode", 32'(bus.opcode), 32'h2);
      chk("c3_operando", 32'(bus.operando), 32'h3);
      hs_tick();                                      // cycle 4
      chk("c4_pc", 32'(pc), 32'h1);
      chk("c4_rd", 32'(bus.mem_rd), 32'h1);
      chk("c4_addr", 32'(bus.mem_addr), 32'h1);

      // Stall in ISSUE with instr_ready low
      bus.instr_ready = 1'b0;
      tick();
      tick();
      chk("stall_valid0", 32'(bus.instr_valid), 32'h1);
      held = bus.instr_out;
      chk("stall_instr0", 32'(held), 32'h45);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("stall_valid", 32'(bus.instr_valid), 32'h1);
         chk("stall_instr", 32'(bus.instr_out), 32'(held));
         chk("stall_pc", 32'(pc), 32'h1);
      end
      bus.instr_ready = 1'b1;
      hs_tick();
      chk("release_estado", 32'(bus.estado), 32'(S_FETCH));
      chk("release_pc", 32'(pc), 32'h2);
      chk("release_valid", 32'(bus.instr_valid), 32'h0);

      // jump_en pulse during WAIT is ignored
      tick();                                         // WAIT
      chk("wait_estado", 32'(bus.estado), 32'(S_WAIT));
      bus.jump_en   = 1'b1;
      bus.jump_addr = 4'h5;
      tick();                                         // ISSUE
      bus.jump_en = 1'b0;
      chk("wait_jump_pc", 32'(pc), 32'h2);
      chk("wait_jump_instr", 32'(bus.instr_out), 32'h67);

      // Jump at handshake to 4'hA
      bus.jump_en   = 1'b1;
      bus.jump_addr = 4'hA;
      hs_tick();
      bus.jump_en = 1'b0;
      chk("jump_addr", 32'(bus.mem_addr), 32'hA);
      chk("jump_rd", 32'(bus.mem_rd), 32'h1);
      tick();
      tick();
      chk("jump_instr", 32'(bus.instr_out), 32'h17);

      // Jump to 4'hF, then wrap to 0
      bus.jump_en   = 1'b1;
      bus.jump_addr = 4'hF;
      hs_tick();
      bus.jump_en = 1'b0;
      chk("to_f_pc", 32'(pc), 32'hF);
      tick();
      tick();
      chk("f_instr", 32'(bus.instr_out), 32'h31);
      mem[0] = 8'hF0;
      hs_tick();
      chk("wrap_pc", 32'(pc), 32'h0);
      chk("wrap_rd", 32'(bus.mem_rd), 32'h1);
      tick();
      tick();
      chk("halt_instr", 32'(bus.instr_out), 32'hF0);
      chk("halt_opcode", 32'(bus.opcode), 32'hF);

      // Halt handshake
      tick();
      chk("halted", 32'(halted), 32'h1);
      chk("halt_pc", 32'(pc), 32'h0);
      chk("halt_valid", 32'(bus.instr_valid), 32'h0);
      start = 1'b1;
      bus.jump_en = 1'b1;
      bus.jump_addr = 4'h7;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("halt_hold_estado", 32'(bus.estado), 32'(S_HALT));
         chk("halt_hold_pc", 32'(pc), 32'h0);
         chk("halt_hold_rd", 32'(bus.mem_rd), 32'h0);
         chk("halt_hold_valid", 32'(bus.instr_valid), 32'h0);
      end
      start = 1'b0;
      bus.jump_en = 1'b0;

      // Reset out of HALT, then reset during WAIT
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_idle("rst_halt");
      mem[0] = 8'h5C;
      start = 1'b1;
      tick();                                         // FETCH
      start = 1'b0;
      tick();                                         // WAIT
      chk("pre_rst_estado", 32'(bus.estado), 32'(S_WAIT));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_idle("rst_wait");
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("post_rst_estado", 32'(bus.estado), 32'(S_IDLE));
         chk("post_rst_valid", 32'(bus.instr_valid), 32'h0);
         chk("post_rst_instr", 32'(bus.instr_out), 32'h0);
      end

`ifdef UNIDADE_BUSCA_STEP_EN
      // Single step: park after handshake until step
      step = 1'b0;
      bus.instr_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("step_valid", 32'(bus.instr_valid), 32'h1);
      chk("step_instr", 32'(bus.instr_out), 32'h5C);
      bus.instr_ready = 1'b1;
      tick();
      bus.instr_ready = 1'b0;
      chk("step_pc", 32'(pc), 32'h1);
      chk("step_park_valid", 32'(bus.instr_valid), 32'h0);
      for (int k = 0; k < 10; k++) begin
         chk("step_park_estado", 32'(bus.estado), 32'(S_ISSUE));
         chk("step_park_rd", 32'(bus.mem_rd), 32'h0);
         tick();
      end
      step = 1'b1;
      tick();
      step = 1'b0;
      chk("step_fetch_rd", 32'(bus.mem_rd), 32'h1);
      chk("step_fetch_addr", 32'(bus.mem_addr), 32'h1);
      n_rd = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (bus.mem_rd) n_rd++;
      end
      chk("step_one_fetch", 32'(n_rd), 32'h0);
      chk("step_issue_valid", 32'(bus.instr_valid), 32'h1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/unidade_busca.md
UNIDADE_BUSCA -- requirements
Module: unidade_busca

Interface
REQ-001 The block SHALL use one clock and synchronous active-high reset. The port list SHALL be as follows, clock and reset first.
- clock  in  1  rising-edge clock for all state.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level; begins fetching from IDLE.
- mem_addr  out  4  program memory address; always equals pc.
- mem_rd  out  1  memory read strobe; one cycle per fetch.
- mem_data  in  8  memory read data; valid on the cycle after mem_rd.
- instr_out  out  8  held instruction byte.
- opcode  out  4  instr_out[7:4].
- operando  out  4  instr_out[3:0].
- instr_valid  out  1  instruction offered to the downstream stage.
- instr_ready  in  1  downstream stage accepts the instruction.
- jump_en  in  1  redirect; sampled only at handshake.
- jump_addr  in  4  redirect target.
- pc  out  4  current program counter.
- halted  out  1  halt opcode retired.
- step  in  1  single-step advance; present only with the macro in REQ-016.

Function
REQ-002 FSM states: IDLE, FETCH, WAIT, ISSUE, HALT.
REQ-003 IDLE SHALL go to FETCH when start=1. Otherwise it SHALL stay in IDLE. All strobes are 0 in IDLE.
REQ-004 FETCH SHALL drive mem_rd=1 for exactly one cycle, then go to WAIT.
REQ-005 WAIT SHALL load mem_data into instr_out at the end of the cycle, then go to ISSUE.
REQ-006 ISSUE SHALL hold instr_valid=1 with instr_out stable until instr_valid and instr_ready are both 1 at a clock edge (the handshake).
REQ-007 At the handshake, if opcode=HALT_OPCODE (4'hF), the FSM SHALL go to HALT and pc SHALL NOT change.
REQ-008 At the handshake, if opcode is not HALT_OPCODE, pc SHALL load jump_addr when jump_en=1, otherwise pc+1. The FSM SHALL then go to FETCH.
REQ-009 pc+1 SHALL wrap from 4'hF to 4'h0 modulo 16, with no flag.
REQ-010 jump_en and jump_addr SHALL be ignored in every cycle other than the handshake cycle.
REQ-011 Latency: start asserted in cycle 0 SHALL give instr_valid=1 in cycle 3. Back-to-back throughput with instr_ready held 1 SHALL be one instruction per 3 cycles.
REQ-012 HALT SHALL drive halted=1 and instr_valid=0. start and step SHALL be ignored. Only reset exits HALT.
REQ-013 instr_ready=1 outside ISSUE SHALL have no effect.

Reset
REQ-014 Reset SHALL take effect on the clock edge and SHALL force the following: state IDLE, pc=0, instr_out=0, mem_rd=0, instr_valid=0, halted=0.
REQ-015 Reset during any state SHALL have priority over all other inputs, including an in-flight read, which SHALL be discarded. No instruction from before the reset SHALL be offered after it.

Configuration
REQ-016 With UNIDADE_BUSCA_STEP_EN defined:
- the step port SHALL exist;
- after a non-halt handshake, the FSM SHALL wait in ISSUE with instr_valid=0 until step=1, then go to FETCH;
- the pc update SHALL still occur at the handshake.
REQ-017 Without UNIDADE_BUSCA_STEP_EN, the step port SHALL be absent and REQ-008 SHALL apply with no wait.

Structure
REQ-018 The shared package unidade_busca_pkg SHALL hold:
- the FSM state enum;
- HALT_OPCODE = 4'hF;
- PC_W = 4;
- INSTR_W = 8.
REQ-019 The program counter SHALL be a sub-module contador_pc with inputs clock, reset, load, inc and load_val[3:0], and output pc[3:0]. Load SHALL have priority over inc.

Verification
REQ-020 Reset, then start=1 with memory[0]=8'h23 and instr_ready=1 -> mem_rd in cycle 1, instr_valid in cycle 3 with instr_out=8'h23, opcode=2, operando=3, pc=1 in cycle 4.
REQ-021 Hold instr_ready=0 for 5 cycles in ISSUE -> instr_valid stays 1 and instr_out is unchanged throughout. Raising instr_ready -> exactly one handshake, then FETCH.
REQ-022 Handshake with jump_en=1 and jump_addr=4'hA -> next mem_addr=4'hA. A jump_en pulse during WAIT -> no effect.
REQ-023 pc=4'hF with non-halt opcode, no jump, handshake -> pc=0. Memory[0]=8'hF0 -> halted=1 and pc stays 0. Further start/instr_ready inputs -> no change.
REQ-024 Reset asserted in WAIT -> next cycle IDLE, instr_out=0, instr_valid=0, pc=0. Stale mem_data is never issued.
REQ-025 With UNIDADE_BUSCA_STEP_EN: after the handshake, no FETCH occurs for 10 cycles with step=0. A single step=1 pulse -> exactly one FETCH.
